imm_decode_stage: RTL
=====================

Name: imm_decode_stage

Overview:
- Registered immediate-decode pipeline stage for the RV32/RV64 front end; sits between fetch and the register-read/execute stage.
- Fully decodes opcode[6:0] into an instruction format and produces an XLEN-wide sign- or zero-extended immediate.
- Carries a sideband tag (PC) through with the instruction.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so that in_ready never depends combinationally on out_ready.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64. The RV64-only opcodes OP-IMM-32 and OP-32 are legal only when XLEN=64.
- TAG_W, 32, width of the sideband tag passed through unchanged.
- ENABLE_ZIMM, 1, when 1, SYSTEM instructions with funct3[2]=1 decode as format Z; when 0, they decode as format I.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband, e.g. PC.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts the entry.
- out_instr  out  32  registered instruction word.
- out_tag  out  TAG_W  registered tag.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, Z=6, ILL=7.
- out_illegal  out  1  high when out_fmt==7.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, skid entry invalid, in_ready=1. All data outputs read as 0: out_instr, out_tag, out_imm, out_fmt=0, out_illegal=0.
- Format decode is combinational on in_instr. The result is registered together with the instruction and tag.
  - instr[1:0] != 2'b11 → ILL.
  - 0110111 (LUI) and 0010111 (AUIPC) → U.
  - 1101111 → J.
  - 1100111, 0000011, 0010011, 0001111 → I.
  - 1100011 → B.
  - 0100011 → S.
  - 0110011 → R.
  - 1110011 → Z if ENABLE_ZIMM and funct3[2], otherwise I.
  - 0011011 → I if XLEN=64, otherwise ILL.
  - 0111011 → R if XLEN=64, otherwise ILL.
  - Any other opcode → ILL.
- Immediate construction; s = instr[31], sign-extended to XLEN unless stated:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Z: instr[19:15], zero-extended.
  - R and ILL: 0.
- Latency: 1 cycle from in_valid&&in_ready to out_valid, assuming the output register is empty or draining.
- Ordering: strict FIFO order, depth 2 (output register plus skid register).
- Handshake:
  - Transfer in occurs when in_valid&&in_ready; transfer out occurs when out_valid&&out_ready.
  - in_ready is a register output, equal to !skid_valid.
  - When output is full, out_ready=0 and an input arrives, the entry goes to the skid register and in_ready drops next cycle.
  - When out_ready and skid_valid, the skid entry moves to the output register and in_ready rises next cycle.
  - Simultaneous in-accept and out-accept with an empty skid: the new entry goes directly to the output register, and out_valid stays 1.
  - Output data is held stable while out_valid && !out_ready.
- Flush:
  - Next cycle: out_valid=0, skid invalid, in_ready=1.
  - An input presented in the flush cycle is discarded.
  - Flush takes priority over every simultaneous event.
- Reset mid-operation: both entries are dropped immediately; there is no partial-state recovery.
- Illegal instructions are not trapped here; they are flagged and passed downstream in order.

Test Plan:
- XLEN=32. Push 0xFFF00093 (addi x1,x0,-1) with out_ready=1 → one cycle later out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0.
- Push in sequence, one per cycle: 0x12345037 (lui), 0xFE000EE3 (beq -4), 0x300FD073 (csrrwi, zimm=31), 0x00000000. Expected in order:
  - lui → imm 0x12345000, fmt 4.
  - beq → imm 0xFFFFFFFC, fmt 3.
  - csrrwi → imm 0x0000001F, fmt 6.
  - 0x00000000 → imm 0, fmt 7, out_illegal=1.
- XLEN=64. Push 0x80000037 (lui) → out_imm=0xFFFFFFFF80000000. Push 0x0000001B (OP-IMM-32) → fmt 1. The same word 0x0000001B at XLEN=32 → fmt 7.
- Backpressure: hold out_ready=0 and offer tags A, B, C back-to-back.
  - A and B are accepted; in_ready=0 from the cycle after B; C is held upstream.
  - Raise out_ready → A, B, C emerge in order with no duplication or loss.
- Flush: with both entries full, assert flush together with in_valid → next cycle out_valid=0 and in_ready=1; the flushed-cycle input never appears at the output.
- Drive rst_n=0 asynchronously mid-stream → out_valid drops without waiting for a clock edge. After release, the first accepted entry appears one cycle later.

Source files
------------

// File: rtl/imm_decode_stage.sv
// Purpose : RV32/RV64 immediate-decode stage; classifies the opcode into an
//           instruction format and builds the XLEN-wide immediate, carrying the
//           instruction word and a sideband tag (PC) alongside.
// Latency : 1 cycle from in_valid&&in_ready to out_valid.
// Backpressure: 2-entry skid (output reg + skid reg); in_ready is a flop output.
// Ports   : clk, rst_n (async, active low), flush (sync kill of both entries),
//           in_valid/in_ready/in_instr/in_tag upstream, out_valid/out_ready/
//           out_instr/out_tag/out_imm/out_fmt/out_illegal downstream.
module imm_decode_stage #(
   parameter int XLEN        = 32,
   parameter int TAG_W       = 32,
   parameter bit ENABLE_ZIMM = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [TAG_W-1:0] out_tag,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal
);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_Z   = 3'd6;
   localparam logic [2:0] FMT_ILL = 3'd7;

   typedef struct packed {
      logic [31:0]      instr;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  imm;
      logic [2:0]       fmt;
   } entry_t;

   // ---------------- combinational decode of the incoming word ----------------
   logic [2:0]  dec_fmt;
   logic [31:0] dec_imm32;
   entry_t      new_ent;

   always_comb begin
      dec_fmt = FMT_ILL;
      if (in_instr[1:0] == 2'b11) begin
         case (in_instr[6:0])
            7'b0110111, 7'b0010111:                         dec_fmt = FMT_U;
            7'b1101111:                                     dec_fmt = FMT_J;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: dec_fmt = FMT_I;
            7'b1100011:                                     dec_fmt = FMT_B;
            7'b0100011:                                     dec_fmt = FMT_S;
            7'b0110011:                                     dec_fmt = FMT_R;
            7'b1110011: dec_fmt = (ENABLE_ZIMM && in_instr[14]) ? FMT_Z : FMT_I;
            // OP-IMM-32 / OP-32 exist only on RV64
            7'b0011011: dec_fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
            7'b0111011: dec_fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
            default:                                        dec_fmt = FMT_ILL;
         endcase
      end
   end

   // Every format's 32-bit immediate is correctly widened by sign-extending
   // bit 31 (Z has bit 31 clear, so it ends up zero-extended).
   always_comb begin
      dec_imm32 = 32'd0;
      case (dec_fmt)
         FMT_I: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FMT_S: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B: dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U: dec_imm32 = {in_instr[31:12], 12'd0};
         FMT_J: dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
         FMT_Z: dec_imm32 = {27'd0, in_instr[19:15]};
         default: dec_imm32 = 32'd0;
      endcase
   end

   always_comb begin
      new_ent       = '0;
      new_ent.instr = in_instr;
      new_ent.tag   = in_tag;
      new_ent.imm   = XLEN'(signed'(dec_imm32));
      new_ent.fmt   = dec_fmt;
   end

   // ---------------- output register + skid register ----------------
   logic   out_vld_q,  out_vld_d;
   logic   skid_vld_q, skid_vld_d;
   entry_t out_ent_q,  out_ent_d;
   entry_t skid_ent_q, skid_ent_d;
   logic   in_fire;

   assign in_ready = !skid_vld_q;
   assign in_fire  = in_valid && in_ready;

   always_comb begin
      out_vld_d  = out_vld_q;
      skid_vld_d = skid_vld_q;
      out_ent_d  = out_ent_q;
      skid_ent_d = skid_ent_q;
      if (flush) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!out_vld_q || out_ready) begin
         // Output slot is free or draining this cycle: refill it, oldest first.
         // in_fire cannot coincide with a valid skid entry (in_ready is low).
         if (skid_vld_q) begin
            out_ent_d  = skid_ent_q;
            out_vld_d  = 1'b1;
            skid_vld_d = 1'b0;
         end else if (in_fire) begin
            out_ent_d = new_ent;
            out_vld_d = 1'b1;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (in_fire) begin
         // Output stalled: park the new entry so in_ready can be a flop.
         skid_ent_d = new_ent;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         out_ent_q  <= '0;
         skid_ent_q <= '0;
      end else begin
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
         out_ent_q  <= out_ent_d;
         skid_ent_q <= skid_ent_d;
      end
   end

   assign out_valid   = out_vld_q;
   assign out_instr   = out_ent_q.instr;
   assign out_tag     = out_ent_q.tag;
   assign out_imm     = out_ent_q.imm;
   assign out_fmt     = out_ent_q.fmt;
   assign out_illegal = (out_ent_q.fmt == FMT_ILL);

endmodule
